multi_seeker_block_aligner: RTL and testbench
=============================================

Name: multi_seeker_block_aligner

Overview:
- Parametrised successor to the hierarchical header seekers: finds and tracks the 66-bit frame boundary inside the gearbox buffer.
- Uses NUM_SEEKERS interleaved seekers, each with its own lock/unlock hysteresis state machine. Lock follows Aurora-style rules: LOCK_CNT consecutive good headers to lock, UNLOCK_BAD bad headers within UNLOCK_WIN frames to unlock.
- A sticky arbiter picks the reported offset.
- Sits between the gearbox and the descrambler/frame extractor.

Parameters:
- NUM_SEEKERS, 4, number of parallel seekers (1..NUM_POS).
- NUM_POS, 66, number of candidate offsets 0..NUM_POS-1.
- BUF_W, 194, gbox_buffer width; must satisfy BUF_W >= NUM_POS+65.
- LOCK_CNT, 64, consecutive valid headers required to lock.
- UNLOCK_BAD, 16, invalid headers within one window that force unlock.
- UNLOCK_WIN, 1024, window length in buffer_dv frames while locked.
- POS_W, $clog2(NUM_POS), offset width (7 at defaults).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- gbox_buffer  in  BUF_W  gearbox buffer; the header at offset p is gbox_buffer[p+65:p+64].
- buffer_dv  in  1  buffer holds a new frame candidate; all seeker updates are qualified by this.
- clear_i  in  1  synchronous soft restart of all seekers and the arbiter.
- is_synced  out  1  a winner seeker is locked.
- offset_pos  out  POS_W  winner's frame offset.
- winner_idx  out  $clog2(NUM_SEEKERS) (min 1)  index of the winning seeker.
- sync_lost_o  out  1  one-cycle pulse when is_synced falls 1->0.

Behaviour:
- Header validity: header at p is valid iff the two bits differ (01 or 10).
- Seeker k owns offsets k, k+NUM_SEEKERS, ... while < NUM_POS.
- Slip: pos <= pos+NUM_SEEKERS. If the result exceeds NUM_POS-1, pos wraps back to k.
- Seeker states: HUNT, LOCKED. Reset/clear: HUNT, pos=k, good=0, bad=0, frm=0.
- HUNT, on dv:
  - Valid header: good++. Reaching LOCK_CNT -> LOCKED with good=0, bad=0, frm=0.
  - Invalid header: slip, good=0.
- LOCKED, on dv: frm++.
  - Invalid header: bad++. Reaching UNLOCK_BAD -> HUNT, slip, all counters cleared.
  - frm reaching UNLOCK_WIN with bad<UNLOCK_BAD: frm=0, bad=0, stay LOCKED.
  - If the unlock and window-end conditions occur on the same frame, unlock wins.
- No dv: seekers hold all state.
- Counters use the minimum width for their terminal value and never wrap.
- Arbiter, registered every cycle from the seeker state registers:
  - If the current winner is LOCKED, keep it (sticky, even if a lower index is also locked).
  - Otherwise select the lowest-index LOCKED seeker.
  - If none is locked, is_synced=0; winner_idx and offset_pos hold their last values.
- Latency: the dv that completes a lock is sampled at edge E. Seeker is LOCKED after E; is_synced, winner_idx and offset_pos update at E+1.
- sync_lost_o is asserted in the cycle after the edge where is_synced goes 1->0. It does not pulse when the winner changes while another seeker is locked.
- Reset values: is_synced=0, offset_pos=0, winner_idx=0, sync_lost_o=0; all seekers in HUNT at pos=k.
- rst_ni asserted mid-operation: immediate return to reset values; no pulse on sync_lost_o.
- clear_i:
  - Equals reset at the next edge and has priority over buffer_dv in the same cycle.
  - sync_lost_o pulses if is_synced was 1.
- NUM_SEEKERS=1: a single seeker scans all offsets; winner_idx is tied to 0.
- NUM_POS not a multiple of NUM_SEEKERS: seekers own unequal offset counts; wrap per the slip rule above.

Test Plan:
- Reset: rst_ni low for 3 cycles with random dv -> all outputs 0. Release with no dv -> outputs remain 0.
- Lock and tie-break:
  - Stimulus: defaults; every dv frame zero except bit 102. This makes offsets 37 and 38 valid.
  - Each of seekers 1 and 2 takes 9 slips, then 64 valid frames; both lock on dv #73.
  - Required: is_synced=1 one edge later with offset_pos=37, winner_idx=1.
- Sticky handover:
  - Stimulus: after lock, switch frames to bit 103 only, so offset 37 is invalid and 38 valid.
  - After the 16th such frame, seeker 1 returns to HUNT and the winner becomes seeker 2: offset_pos=38, winner_idx=2.
  - is_synced stays 1; sync_lost_o stays 0.
- Window hysteresis:
  - 15 invalid frames spread across a 1024-frame window, then 15 more in the next window -> remains locked, offset unchanged.
  - 16 invalid frames within one window -> unlock.
- Loss and wrap:
  - Stimulus: all-zero frames for 20 dv after lock -> is_synced falls; sync_lost_o is one cycle high.
  - Seeker 1 offset walks 37,41,...,65,1. Seeker 2 walks ...,62,2.
- clear_i:
  - Asserted while locked, with dv high in the same cycle -> next cycle is_synced=0, sync_lost_o=1, all seekers at pos=k.
  - Relock follows the same 73-dv timing.

Source files
------------

// File: rtl/multi_seeker_block_aligner.sv
// Finds and tracks the 66-bit frame boundary in the gearbox buffer. Several
// interleaved seekers each hunt and lock one subset of offsets, and a sticky arbiter picks the offset that is reported.

module msba_seeker #(
  parameter int K           = 0,
  parameter int NUM_SEEKERS = 4,
  parameter int NUM_POS     = 66,
  parameter int BUF_W       = 194,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_BAD  = 16,
  parameter int UNLOCK_WIN  = 1024,
  parameter int POS_W       = $clog2(NUM_POS)
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic             buffer_dv,
  input  logic             clear_i,
  output logic             locked,
  output logic [POS_W-1:0] pos
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int FW = $clog2(UNLOCK_WIN + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           st, st_n;
  logic [POS_W-1:0] pos_n, slip_pos;
  logic [POS_W:0]   slip_sum;
  logic [GW-1:0]    good, good_n;
  logic [BW-1:0]    bad, bad_n;
  logic [FW-1:0]    frm, frm_n;
  logic [1:0]       hdr;
  logic             hdr_ok;

  assign hdr      = gbox_buffer[int'(pos) + 64 +: 2];
  assign hdr_ok   = hdr[1] ^ hdr[0];
  assign slip_sum = {1'b0, pos} + (POS_W+1)'(NUM_SEEKERS);
  // Past the last candidate offset, go back to this seeker's first one.
  assign slip_pos = (slip_sum > (POS_W+1)'(NUM_POS - 1)) ? POS_W'(K) : slip_sum[POS_W-1:0];
  assign locked   = (st == LOCKED);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st   <= HUNT;
      pos  <= POS_W'(K);
      good <= '0;
      bad  <= '0;
      frm  <= '0;
    end else begin
      st   <= st_n;
      pos  <= pos_n;
      good <= good_n;
      bad  <= bad_n;
      frm  <= frm_n;
    end
  end

  always_comb begin
    st_n   = st;
    pos_n  = pos;
    good_n = good;
    bad_n  = bad;
    frm_n  = frm;
    if (clear_i) begin
      st_n   = HUNT;
      pos_n  = POS_W'(K);
      good_n = '0;
      bad_n  = '0;
      frm_n  = '0;
    end else if (buffer_dv) begin
      case (st)
        HUNT: begin
          if (hdr_ok) begin
            if (good == GW'(LOCK_CNT - 1)) begin
              st_n   = LOCKED;
              good_n = '0;
              bad_n  = '0;
              frm_n  = '0;
            end else begin
              good_n = good + 1'b1;
            end
          end else begin
            pos_n  = slip_pos;
            good_n = '0;
          end
        end
        LOCKED: begin
          // An unlock takes priority over a window ending on the same frame.
          if (!hdr_ok && bad == BW'(UNLOCK_BAD - 1)) begin
            st_n   = HUNT;
            pos_n  = slip_pos;
            good_n = '0;
            bad_n  = '0;
            frm_n  = '0;
          end else if (frm == FW'(UNLOCK_WIN - 1)) begin
            frm_n = '0;
            bad_n = '0;
          end else begin
            frm_n = frm + 1'b1;
            if (!hdr_ok) bad_n = bad + 1'b1;
          end
        end
        default: st_n = HUNT;
      endcase
    end
  end
endmodule

module multi_seeker_block_aligner #(
  parameter int NUM_SEEKERS = 4,
  parameter int NUM_POS     = 66,
  parameter int BUF_W       = 194,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_BAD  = 16,
  parameter int UNLOCK_WIN  = 1024,
  parameter int POS_W       = $clog2(NUM_POS),
  parameter int IDX_W       = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic             buffer_dv,
  input  logic             clear_i,
  output logic             is_synced,
  output logic [POS_W-1:0] offset_pos,
  output logic [IDX_W-1:0] winner_idx,
  output logic             sync_lost_o
);
  logic [NUM_SEEKERS-1:0]            locked;
  logic [NUM_SEEKERS-1:0][POS_W-1:0] pos;
  logic [IDX_W-1:0]                  sel;
  logic                              any_lock;

  for (genvar k = 0; k < NUM_SEEKERS; k++) begin : g_seek
    msba_seeker #(
      .K(k), .NUM_SEEKERS(NUM_SEEKERS), .NUM_POS(NUM_POS), .BUF_W(BUF_W),
      .LOCK_CNT(LOCK_CNT), .UNLOCK_BAD(UNLOCK_BAD), .UNLOCK_WIN(UNLOCK_WIN), .POS_W(POS_W)
    ) u_seek (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .gbox_buffer(gbox_buffer),
      .buffer_dv  (buffer_dv),
      .clear_i    (clear_i),
      .locked     (locked[k]),
      .pos        (pos[k])
    );
  end

  // A locked winner is kept; otherwise the lowest-index locked seeker wins.
  always_comb begin
    any_lock = |locked;
    sel      = winner_idx;
    if (!(is_synced && locked[winner_idx])) begin
      sel = '0;
      for (int i = NUM_SEEKERS - 1; i >= 0; i--)
        if (locked[i]) sel = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_synced   <= 1'b0;
      offset_pos  <= '0;
      winner_idx  <= '0;
      sync_lost_o <= 1'b0;
    end else if (clear_i) begin
      is_synced   <= 1'b0;
      offset_pos  <= '0;
      winner_idx  <= '0;
      sync_lost_o <= is_synced;
    end else begin
      is_synced   <= any_lock;
      sync_lost_o <= is_synced && !any_lock;
      if (any_lock) begin
        winner_idx <= sel;
        offset_pos <= pos[sel];
      end
    end
  end
endmodule

// File: tb/tb_multi_seeker_block_aligner.sv
// Self-checking bench for multi_seeker_block_aligner with an offset-level
// behavioural model of the seekers and the arbiter.

module tb_multi_seeker_block_aligner;
  localparam int NS = 4, NP = 66, BW = 194, LC = 64, UB = 16, UW = 1024, PW = 7, IW = 2;

  logic          clk_i = 0, rst_ni = 1;
  logic [BW-1:0] gbox_buffer = '0;
  logic          buffer_dv = 0, clear_i = 0;
  logic          is_synced, sync_lost_o;
  logic [PW-1:0] offset_pos;
  logic [IW-1:0] winner_idx;

  multi_seeker_block_aligner dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gbox_buffer(gbox_buffer), .buffer_dv(buffer_dv),
    .clear_i(clear_i), .is_synced(is_synced), .offset_pos(offset_pos),
    .winner_idx(winner_idx), .sync_lost_o(sync_lost_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0, lost_seen = 0;
  int m_pos[NS], m_good[NS], m_bad[NS], m_frm[NS];
  bit m_lock[NS];
  bit m_sync, m_lost;
  int m_win, m_off;
  logic [BW-1:0] fz, f102, f103;

  function automatic logic [IW+PW+1:0] got();
    return {is_synced, winner_idx, offset_pos, sync_lost_o};
  endfunction

  function automatic logic [IW+PW+1:0] expv();
    return {m_sync, IW'(m_win), PW'(m_off), m_lost};
  endfunction

  function automatic logic [BW-1:0] rand_buf();
    logic [BW-1:0] b;
    for (int i = 0; i < BW; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_pos[k] = k; m_good[k] = 0; m_bad[k] = 0; m_frm[k] = 0; m_lock[k] = 0;
    end
    m_sync = 0; m_lost = 0; m_win = 0; m_off = 0;
  endtask

  task automatic model_step(input bit dv, input logic [BW-1:0] b, input bit clr);
    bit old, ok;
    int f, p;
    old = m_sync;
    if (clr) begin
      model_reset();
      m_lost = old;
      return;
    end
    f = -1;
    if (m_sync && m_lock[m_win]) f = m_win;
    else for (int k = NS - 1; k >= 0; k--) if (m_lock[k]) f = k;
    if (f >= 0) begin m_sync = 1; m_win = f; m_off = m_pos[f]; end
    else m_sync = 0;
    m_lost = old && !m_sync;
    if (!dv) return;
    for (int k = 0; k < NS; k++) begin
      ok = b[m_pos[k] + 65] != b[m_pos[k] + 64];
      p = m_pos[k] + NS;
      if (p > NP - 1) p = k;
      if (!m_lock[k]) begin
        if (ok) begin
          m_good[k]++;
          if (m_good[k] == LC) begin m_lock[k] = 1; m_good[k] = 0; end
        end else begin
          m_pos[k] = p; m_good[k] = 0;
        end
      end else begin
        m_frm[k]++;
        if (!ok) m_bad[k]++;
        if (m_bad[k] == UB) begin
          m_lock[k] = 0; m_pos[k] = p; m_bad[k] = 0; m_frm[k] = 0; m_good[k] = 0;
        end else if (m_frm[k] == UW) begin
          m_frm[k] = 0; m_bad[k] = 0;
        end
      end
    end
  endtask

  task automatic tick(input bit dv, input logic [BW-1:0] b, input bit clr);
    buffer_dv = dv; gbox_buffer = b; clear_i = clr;
    @(posedge clk_i);
    model_step(dv, b, clr);
    #1;
    buffer_dv = 0; clear_i = 0;
    if (sync_lost_o === 1'b1) lost_seen++;
  endtask

  // One dv frame, sometimes preceded by an idle cycle.
  task automatic frame(input logic [BW-1:0] b);
    if ($urandom_range(0, 3) == 0) tick(0, b, 0);
    tick(1, b, 0);
  endtask

  task automatic test_reset();
    #1 rst_ni = 0;
    model_reset();
    repeat (3) begin
      buffer_dv = 1'($urandom_range(0, 1)); gbox_buffer = rand_buf();
      @(posedge clk_i); #1;
      n_cmp++;
      if (got() !== '0) begin n_err++; $display("FAIL reset_hold got=%h exp=0", got()); end
    end
    buffer_dv = 0; rst_ni = 1;
    repeat (2) begin
      tick(0, fz, 0);
      n_cmp++;
      if (got() !== '0) begin n_err++; $display("FAIL reset_release got=%h exp=0", got()); end
    end
  endtask

  task automatic test_lock();
    for (int n = 1; n <= 73; n++) begin
      frame(f102);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL lock_model dv=%0d got=%h exp=%h", n, got(), expv()); end
      if (n >= 72) begin
        n_cmp++;
        if (is_synced !== 1'b0) begin n_err++; $display("FAIL lock_early dv=%0d is_synced=%b exp=0", n, is_synced); end
      end
    end
    tick(0, f102, 0);
    n_cmp++;
    if ({is_synced, winner_idx, offset_pos, sync_lost_o} !== {1'b1, 2'd1, 7'd37, 1'b0}) begin
      n_err++; $display("FAIL lock_tiebreak got=%h exp=%h", got(), {1'b1, 2'd1, 7'd37, 1'b0});
    end
  endtask

  task automatic test_sticky();
    lost_seen = 0;
    for (int n = 1; n <= 16; n++) begin
      frame(f103);
      n_cmp++;
      if ({is_synced, winner_idx, offset_pos} !== {1'b1, 2'd1, 7'd37}) begin
        n_err++; $display("FAIL sticky_hold dv=%0d got=%h exp=%h", n, got(), {1'b1, 2'd1, 7'd37, 1'b0});
      end
    end
    tick(0, f103, 0);
    n_cmp++;
    if ({is_synced, winner_idx, offset_pos, sync_lost_o} !== {1'b1, 2'd2, 7'd38, 1'b0}) begin
      n_err++; $display("FAIL sticky_handover got=%h exp=%h", got(), {1'b1, 2'd2, 7'd38, 1'b0});
    end
    n_cmp++;
    if (lost_seen !== 0) begin n_err++; $display("FAIL sticky_no_pulse pulses=%0d exp=0", lost_seen); end
  endtask

  task automatic test_window();
    int i;
    i = 0;
    // Run to the winner's window boundary with a few scattered bad frames.
    while (m_frm[2] != 0 && i < 2000) begin
      frame((i % 100 == 99) ? fz : f103);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL window_align_model got=%h exp=%h", got(), expv()); end
      i++;
    end
    n_cmp++;
    if (i >= 2000) begin n_err++; $display("FAIL window_align_timeout frames=%0d exp<2000", i); end
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < UW; j++) begin
        frame((j % 64 == 10 && j < 960) ? fz : f103);
        n_cmp++;
        if (got() !== expv()) begin n_err++; $display("FAIL window_15bad_model w=%0d f=%0d got=%h exp=%h", w, j, got(), expv()); end
      end
    n_cmp++;
    if ({is_synced, winner_idx, offset_pos} !== {1'b1, 2'd2, 7'd38}) begin
      n_err++; $display("FAIL window_15bad_locked got=%h exp=%h", got(), {1'b1, 2'd2, 7'd38, 1'b0});
    end
    n_cmp++;
    if (lost_seen !== 0) begin n_err++; $display("FAIL window_no_pulse pulses=%0d exp=0", lost_seen); end
    for (int j = 0; j <= 120; j++) begin
      frame((j % 8 == 0) ? fz : f103);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL window_16bad_model f=%0d got=%h exp=%h", j, got(), expv()); end
    end
    tick(0, f103, 0);
    n_cmp++;
    if (is_synced === 1'b1 && winner_idx === 2'd2) begin
      n_err++; $display("FAIL window_16bad_unlock winner=%0d synced=%b exp=not seeker 2", winner_idx, is_synced);
    end
  endtask

  task automatic test_loss_relock();
    for (int j = 0; j < 40; j++) begin
      frame(fz);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL loss_model f=%0d got=%h exp=%h", j, got(), expv()); end
    end
    tick(0, fz, 0);
    n_cmp++;
    if (is_synced !== 1'b0 || lost_seen !== 1) begin
      n_err++; $display("FAIL loss_pulse synced=%b pulses=%0d exp synced=0 pulses=1", is_synced, lost_seen);
    end
    for (int j = 0; j < 400; j++) begin
      frame(f102);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL relock_wrap_model f=%0d got=%h exp=%h", j, got(), expv()); end
    end
    tick(0, f102, 0);
    n_cmp++;
    if (is_synced !== 1'b1) begin n_err++; $display("FAIL relock_wrap synced=%b exp=1", is_synced); end
  endtask

  task automatic test_clear();
    tick(1, f102, 1);
    n_cmp++;
    if ({is_synced, sync_lost_o, winner_idx, offset_pos} !== {1'b0, 1'b1, 2'd0, 7'd0}) begin
      n_err++; $display("FAIL clear_pulse got=%h exp synced=0 lost=1 idx=0 pos=0", got());
    end
    tick(0, f102, 0);
    n_cmp++;
    if (sync_lost_o !== 1'b0) begin n_err++; $display("FAIL clear_pulse_width lost=%b exp=0", sync_lost_o); end
    for (int n = 1; n <= 73; n++) begin
      frame(f102);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL clear_relock_model dv=%0d got=%h exp=%h", n, got(), expv()); end
    end
    n_cmp++;
    if (is_synced !== 1'b0) begin n_err++; $display("FAIL clear_relock_early synced=%b exp=0", is_synced); end
    tick(0, f102, 0);
    n_cmp++;
    if ({is_synced, winner_idx, offset_pos} !== {1'b1, 2'd1, 7'd37}) begin
      n_err++; $display("FAIL clear_relock got=%h exp=%h", got(), {1'b1, 2'd1, 7'd37, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    lost_seen = 0;
    #2 rst_ni = 0;
    #1;
    model_reset();
    n_cmp++;
    if (got() !== '0) begin n_err++; $display("FAIL reset_mid_async got=%h exp=0", got()); end
    @(posedge clk_i); #1 rst_ni = 1;
    repeat (3) tick(0, f102, 0);
    n_cmp++;
    if (got() !== expv() || lost_seen !== 0) begin
      n_err++; $display("FAIL reset_mid_quiet got=%h exp=%h pulses=%0d", got(), expv(), lost_seen);
    end
  endtask

  task automatic test_random();
    int t;
    logic [BW-1:0] b;
    bit clr;
    t = $urandom_range(0, NP - 1);
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 699) t = $urandom_range(0, NP - 1);
      b = rand_buf();
      if ($urandom_range(0, 99) < 96) b[t + 65] = ~b[t + 64];
      clr = ($urandom_range(0, 499) == 0);
      tick(1'($urandom_range(0, 3) != 0), b, clr);
      n_cmp++;
      if (got() !== expv()) begin n_err++; $display("FAIL random_model c=%0d got=%h exp=%h", c, got(), expv()); end
    end
  endtask

  initial begin
    fz = '0;
    f102 = '0; f102[102] = 1'b1;
    f103 = '0; f103[103] = 1'b1;
    model_reset();
    test_reset();
    test_lock();
    test_sticky();
    test_window();
    test_loss_relock();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
